datamem_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer in front of the single-port data memory.

---
 rtl/datamem_arbiter.sv | 141 ++++++++++++++
 tb/tb_datamem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port data memory.
// Optional address checking is enabled by defining ARB_ERR_EN.
module datamem_arbiter #(
  parameter int RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sel;
  logic        r_last;
  logic        r_wr;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_anyReq;
  logic        w_pick;
  logic        w_pickWr;
  logic        w_pickErr;
  logic [31:0] w_pickAddr;
  logic [31:0] w_pickWdata;

  // On a tie the port that was not served last wins.
  always_comb begin
    w_anyReq    = req0 | req1;
    w_pick      = (req0 && req1) ? ~r_last : req1;
    w_pickWr    = w_pick ? wr1 : wr0;
    w_pickAddr  = w_pick ? addr1 : addr0;
    w_pickWdata = w_pick ? wdata1 : wdata0;
`ifdef ARB_ERR_EN
    w_pickErr   = (w_pickAddr[1:0] != 2'b00) || (w_pickAddr[31:2] >= 30'(RAM_SIZE));
`else
    w_pickErr   = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_anyReq) begin
        r_sel   <= w_pick;
        r_last  <= w_pick;
        r_wr    <= w_pickWr;
        r_err   <= w_pickErr;
        r_addr  <= w_pickAddr;
        r_wdata <= w_pickWdata;
      end
      // A suppressed access returns zero rather than whatever the memory drives.
      if (r_state == ACCESS) begin
        r_rdata <= (r_wr || r_err) ? 32'd0 : mem_rdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    rdata0    = 32'd0;
    rdata1    = 32'd0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    case (r_state)
      ACCESS: begin
        gnt0   = ~r_sel;
        gnt1   = r_sel;
        mem_rd = ~r_wr & ~r_err;
        mem_wr = r_wr & ~r_err;
      end
      RESP: begin
        done0 = ~r_sel;
        done1 = r_sel;
        if (!r_wr) begin
          if (r_sel) rdata1 = r_rdata;
          else       rdata0 = r_rdata;
        end
`ifdef ARB_ERR_EN
        err0 = ~r_sel & r_err;
        err1 = r_sel & r_err;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized self-checking bench for datamem_arbiter against a transaction-level model.
// Build with ARB_ERR_EN defined to exercise the address-check variant.
module tb_datamem_arbiter;
  localparam int RAM_SIZE = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  datamem_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Bench-side memory; addresses alias on bits [9:2].
  logic [31:0] memArr [256];
  assign mem_rdata = memArr[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) memArr[mem_addr[9:2]] <= mem_wdata;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqT;

  reqT q0[$];
  reqT q1[$];
  reqT cur[2];
  bit  active[2];
  bit  randomMode = 1'b0;

  // Transaction-level model: one pending access identified by the slot in which it executes.
  logic [31:0] modelMem [256];
  int          slot;
  int          capSlot;
  bit          capPort, capWr, capErr, lastServed;
  logic [31:0] capAddr, capWdata, capRead, abortOld;

  int gntSlots[$];
  bit gntPorts[$];
  logic [31:0] done0Rdata[$];
  int memWrPulses;
  int err0Count;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at slot %0d: got %h expected %h", name, slot, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " gnt0"}, 32'(gnt0), 0);
    checkVal({tag, " gnt1"}, 32'(gnt1), 0);
    checkVal({tag, " done0"}, 32'(done0), 0);
    checkVal({tag, " done1"}, 32'(done1), 0);
    checkVal({tag, " rdata0"}, rdata0, 0);
    checkVal({tag, " rdata1"}, rdata1, 0);
    checkVal({tag, " err0"}, 32'(err0), 0);
    checkVal({tag, " err1"}, 32'(err1), 0);
    checkVal({tag, " mem_rd"}, 32'(mem_rd), 0);
    checkVal({tag, " mem_wr"}, 32'(mem_wr), 0);
    checkVal({tag, " mem_addr"}, mem_addr, 0);
    checkVal({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic reqT mkReq(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    reqT r;
    r.wr = wr; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic reqT randReq();
    reqT r;
    logic [7:0] idx;
    idx     = 8'($urandom_range(0, 255));
    r.wr    = 1'($urandom_range(0, 1));
    r.addr  = {22'd0, idx, 2'b00};
    r.wdata = $urandom;
    case ($urandom_range(0, 7))
      0: r.addr[1:0] = 2'($urandom_range(1, 3));
      1: r.addr[10] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit modelErr(input logic [31:0] a);
`ifdef ARB_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(RAM_SIZE));
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic resetModel();
    slot = 0; capSlot = -10; capPort = 0; capWr = 0; capErr = 0;
    lastServed = 1; capAddr = 0; capWdata = 0; capRead = 0;
    active[0] = 0; active[1] = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic checkOutput();
    bit inAcc, inResp;
    logic [31:0] expRd;
    inAcc  = (slot == capSlot);
    inResp = (slot == capSlot + 1);
    expRd  = (inResp && !capWr && !capErr) ? capRead : 32'd0;
    checkVal("gnt0", 32'(gnt0), 32'(inAcc && !capPort));
    checkVal("gnt1", 32'(gnt1), 32'(inAcc && capPort));
    checkVal("done0", 32'(done0), 32'(inResp && !capPort));
    checkVal("done1", 32'(done1), 32'(inResp && capPort));
    checkVal("rdata0", rdata0, capPort ? 32'd0 : expRd);
    checkVal("rdata1", rdata1, capPort ? expRd : 32'd0);
    checkVal("err0", 32'(err0), 32'(inResp && capErr && !capPort));
    checkVal("err1", 32'(err1), 32'(inResp && capErr && capPort));
    checkVal("mem_rd", 32'(mem_rd), 32'(inAcc && !capWr && !capErr));
    checkVal("mem_wr", 32'(mem_wr), 32'(inAcc && capWr && !capErr));
    checkVal("mem_addr", mem_addr, capAddr);
    checkVal("mem_wdata", mem_wdata, capWdata);
    if (gnt0 === 1'b1) begin gntSlots.push_back(slot); gntPorts.push_back(1'b0); end
    if (gnt1 === 1'b1) begin gntSlots.push_back(slot); gntPorts.push_back(1'b1); end
    if (done0 === 1'b1) done0Rdata.push_back(rdata0);
    if (mem_wr === 1'b1) memWrPulses++;
    if (err0 === 1'b1) err0Count++;
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < 2; p++) begin
      if (active[p] && slot == capSlot && int'(capPort) == p) active[p] = 0;
      if (!active[p]) begin
        if (p == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); active[0] = 1; end
        else if (p == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); active[1] = 1; end
        else if (randomMode && $urandom_range(0, 2) == 0) begin cur[p] = randReq(); active[p] = 1; end
        else cur[p] = randReq();
      end
    end
    req0 = active[0]; wr0 = cur[0].wr; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
    req1 = active[1]; wr1 = cur[1].wr; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
  endtask

  task automatic modelCapture();
    bit p;
    int idx;
    if (slot >= capSlot + 2 && (active[0] || active[1])) begin
      p        = (active[0] && active[1]) ? !lastServed : active[1];
      capSlot  = slot + 1;
      capPort  = p;
      capWr    = cur[p].wr;
      capAddr  = cur[p].addr;
      capWdata = cur[p].wdata;
      capErr   = modelErr(capAddr);
      idx      = int'(capAddr[9:2]);
      capRead  = modelMem[idx];
      abortOld = modelMem[idx];
      if (capWr && !capErr) modelMem[idx] = capWdata;
      lastServed = p;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    slot++;
    checkOutput();
    applyStimulus();
    modelCapture();
  endtask

  task automatic drain();
    int n;
    randomMode = 0;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || active[0] || active[1] || slot < capSlot + 2) && n < 60) begin
      stepCycle();
      n++;
    end
    checkVal("drain timeout", 32'(n < 60), 1);
  endtask

  task automatic clearLogs();
    gntSlots.delete(); gntPorts.delete(); done0Rdata.delete();
    memWrPulses = 0; err0Count = 0;
  endtask

  initial begin
    int t0, n;
    logic [31:0] expWord0;
    for (int i = 0; i < 256; i++) begin
      memArr[i]   = $urandom;
      modelMem[i] = memArr[i];
    end
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    reset = 1'b1;
    resetModel();
    #1 checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;
    resetModel();
    clearLogs();

    // Port 0 write then read of the same word, back to back.
    stepCycle();
    t0 = slot;
    q0.push_back(mkReq(1'b1, 32'h10, 32'hDEADBEEF));
    q0.push_back(mkReq(1'b0, 32'h10, 32'h0));
    for (int i = 0; i < 8; i++) stepCycle();
    checkVal("t1 gnt count", gntSlots.size(), 2);
    if (gntSlots.size() >= 2) begin
      checkVal("t1 gnt latency", gntSlots[0] - t0, 2);
      checkVal("t1 gnt spacing", gntSlots[1] - gntSlots[0], 3);
    end
    checkVal("t1 done count", done0Rdata.size(), 2);
    if (done0Rdata.size() >= 2) checkVal("t1 read data", done0Rdata[1], 32'hDEADBEEF);
    drain();

    // Port 1 alone with four queued accesses: served every third cycle.
    clearLogs();
    for (int i = 0; i < 4; i++) q1.push_back(mkReq(1'b0, 32'(i * 4), 0));
    for (int i = 0; i < 14; i++) stepCycle();
    checkVal("t3 gnt count", gntSlots.size(), 4);
    if (gntSlots.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkVal("t3 port", 32'(gntPorts[i]), 1);
      for (int i = 1; i < 4; i++) checkVal("t3 spacing", gntSlots[i] - gntSlots[i-1], 3);
    end
    drain();

    // Reset asserted while a port 1 write is in its access cycle.
    q1.push_back(mkReq(1'b1, 32'h20, 32'h12345678));
    n = 0;
    do begin stepCycle(); n++; end while (!(slot == capSlot && capPort) && n < 10);
    checkVal("t4 reach access", 32'(n < 10), 1);
    checkVal("t4 gnt1 before reset", 32'(gnt1), 1);
    #2 reset = 1'b1;
    req0 = 0; req1 = 0;
    #1 checkAllZero("t4 async");
    if (capWr && !capErr) modelMem[int'(capAddr[9:2])] = abortOld;
    @(negedge clk);
    checkAllZero("t4 held");
    reset = 1'b0;
    resetModel();
    clearLogs();

    // Simultaneous requests after reset: strict alternation starting with port 0.
    q0.push_back(mkReq(1'b0, 32'h0, 0)); q0.push_back(mkReq(1'b0, 32'h0, 0));
    q1.push_back(mkReq(1'b0, 32'h4, 0)); q1.push_back(mkReq(1'b0, 32'h4, 0));
    for (int i = 0; i < 14; i++) stepCycle();
    checkVal("t2 gnt count", gntSlots.size(), 4);
    if (gntSlots.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkVal("t2 order", 32'(gntPorts[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) checkVal("t2 spacing", gntSlots[i] - gntSlots[i-1], 3);
    end
    drain();

    // Misaligned and out-of-range writes, then read word 0.
    q0.push_back(mkReq(1'b1, 32'h0, 32'h0BADF00D));
    drain();
    clearLogs();
    q0.push_back(mkReq(1'b1, 32'h2, 32'hAAAA5555));
    q0.push_back(mkReq(1'b1, 32'(RAM_SIZE * 4), 32'h5555AAAA));
    q0.push_back(mkReq(1'b0, 32'h0, 0));
    drain();
`ifdef ARB_ERR_EN
    checkVal("t5 mem_wr pulses", memWrPulses, 0);
    checkVal("t5 err0 count", err0Count, 2);
    expWord0 = 32'h0BADF00D;
`else
    checkVal("t6 mem_wr pulses", memWrPulses, 2);
    checkVal("t6 err0 count", err0Count, 0);
    expWord0 = 32'h5555AAAA;
`endif
    checkVal("t5 done count", done0Rdata.size(), 3);
    if (done0Rdata.size() >= 3) checkVal("t5 read word0", done0Rdata[2], expWord0);

    // Randomized traffic on both ports.
    randomMode = 1;
    for (int i = 0; i < 2000; i++) stepCycle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
